// File: rtl/bus_fifo_port.sv
// bus_fifo_port: memory-mapped CPU bus responder with a TX FIFO drained over a
// valid/ready stream and an RX FIFO filled from a valid/ready stream.
//
// Stream handshakes: a byte moves on a clock edge where valid and ready are
// both high. The source holds data and valid until that edge. Ready never
// depends on valid.
//
// Bus accesses are strobe-edge driven. A write commits on the w rise. A read
// drives data_bus combinationally for the whole r pulse, and any pop happens
// on the r fall, so the CPU never sees the FIFO head shift under it. An access
// with r and w high together is discarded.
module bus_fifo_port #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address_bus,
    inout  wire  [7:0]  data_bus,
    input  logic        r,
    input  logic        w,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t       PTR_ONE  = ptr_t'(1);
    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    // Saturate a FIFO occupancy to the 4-bit COUNT field.
    function automatic logic [3:0] sat4(input ptr_t c);
        logic [7:0] wide;
        wide = 8'(c);
        return (wide > 8'd15) ? 4'hF : wide[3:0];
    endfunction

    // ------------------------------------------------------------------
    // Bus decode and strobe edge tracking
    // ------------------------------------------------------------------
    logic       sel;
    logic       r_q;
    logic       w_q;
    logic       sel_q;
    logic [1:0] addr_q;
    // abort_q blocks any commit until both strobes have been seen low; it is
    // set by an r&w collision or by a reset that lands mid-access.
    logic       abort_q;

    assign sel = (address_bus[15:2] == BASE_ADDR[15:2]);

    // Registered copies of the bus strobes and address for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= 1'b0;
            w_q     <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= 2'd0;
            abort_q <= r | w;
        end else begin
            r_q     <= r;
            w_q     <= w;
            sel_q   <= sel;
            addr_q  <= address_bus[1:0];
            abort_q <= (r & w) | (abort_q & (r | w));
        end
    end

    logic wr_evt;
    logic wr_data;
    logic wr_status;
    logic wr_ctrl;
    logic rd_pop_req;

    assign wr_evt     = w & ~w_q & sel & ~r & ~abort_q;
    assign wr_data    = wr_evt & (address_bus[1:0] == A_DATA);
    assign wr_status  = wr_evt & (address_bus[1:0] == A_STATUS);
    assign wr_ctrl    = wr_evt & (address_bus[1:0] == A_CTRL);
    assign rd_pop_req = r_q & ~r & sel_q & ~abort_q & (addr_q == A_DATA);

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0] tx_mem [DEPTH];
    ptr_t       tx_wptr;
    ptr_t       tx_rptr;
    ptr_t       tx_wptr_n;
    ptr_t       tx_rptr_n;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_pop;
    logic       tx_push;
    logic       tx_ovf_set;
    logic       tx_ovf;

    assign tx_empty   = (tx_wptr == tx_rptr);
    assign tx_full    = (tx_wptr[AW] != tx_rptr[AW]) &&
                        (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
    assign tx_pop     = ~tx_empty & tx_ready;
    // A pop on the same edge frees the slot a push into a full FIFO needs.
    assign tx_push    = wr_data & (~tx_full | tx_pop);
    assign tx_ovf_set = wr_data & tx_full & ~tx_pop;
    assign tx_wptr_n  = tx_push ? tx_wptr + PTR_ONE : tx_wptr;
    assign tx_rptr_n  = tx_pop  ? tx_rptr + PTR_ONE : tx_rptr;
    assign tx_valid   = ~tx_empty;
    assign tx_data    = tx_mem[tx_rptr[AW-1:0]];

    // TX storage; contents carry no reset value.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= data_bus;
    end

    // TX pointers and overflow flag (a new overflow beats a same-cycle clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_ovf  <= 1'b0;
        end else begin
            tx_wptr <= tx_wptr_n;
            tx_rptr <= tx_rptr_n;
            tx_ovf  <= tx_ovf_set | (tx_ovf & ~(wr_status & data_bus[2]));
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0] rx_mem [DEPTH];
    ptr_t       rx_wptr;
    ptr_t       rx_rptr;
    ptr_t       rx_wptr_n;
    ptr_t       rx_rptr_n;
    logic       rx_full;
    logic       rx_empty;
    logic       rx_push;
    logic       rx_pop;
    logic       rx_udf_set;
    logic       rx_udf;

    assign rx_empty   = (rx_wptr == rx_rptr);
    assign rx_full    = (rx_wptr[AW] != rx_rptr[AW]) &&
                        (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
    assign rx_ready   = ~rx_full & ~reset;
    assign rx_push    = rx_valid & rx_ready;
    assign rx_pop     = rd_pop_req & ~rx_empty;
    assign rx_udf_set = rd_pop_req & rx_empty;
    assign rx_wptr_n  = rx_push ? rx_wptr + PTR_ONE : rx_wptr;
    assign rx_rptr_n  = rx_pop  ? rx_rptr + PTR_ONE : rx_rptr;

    // RX storage; contents carry no reset value.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_data;
    end

    // RX pointers and underflow flag (a new underflow beats a same-cycle clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_udf  <= 1'b0;
        end else begin
            rx_wptr <= rx_wptr_n;
            rx_rptr <= rx_rptr_n;
            rx_udf  <= rx_udf_set | (rx_udf & ~(wr_status & data_bus[3]));
        end
    end

    // ------------------------------------------------------------------
    // Control and interrupt
    // ------------------------------------------------------------------
    logic irq_en;
    logic irq_en_n;

    assign irq_en_n = wr_ctrl ? data_bus[0] : irq_en;

    // irq is built from next-state values so it follows an RX handshake or
    // pop by exactly one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq_en <= irq_en_n;
            irq    <= irq_en_n & (rx_wptr_n != rx_rptr_n);
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    logic [7:0] rd_data;

    // Combinational register read mux, stable for the whole r pulse.
    always_comb begin
        rd_data = 8'h00;
        unique case (address_bus[1:0])
            A_DATA:   rd_data = rx_empty ? 8'h00 : rx_mem[rx_rptr[AW-1:0]];
            A_STATUS: rd_data = {4'b0000, rx_udf, tx_ovf, ~rx_empty, tx_full};
            A_COUNT:  rd_data = {sat4(tx_wptr - tx_rptr), sat4(rx_wptr - rx_rptr)};
            A_CTRL:   rd_data = {7'b0000000, irq_en};
            default:  rd_data = 8'h00;
        endcase
    end

    assign data_bus = (r & sel) ? rd_data : 8'bzzzz_zzzz;

endmodule
